// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; result = {remainder, quotient}.
// Signed (DIV) support is compiled in only when DIV_SIGNED_EN is defined.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} state_t;

  state_t             state;
  logic [DATA_W-1:0]  dvd;
  logic [DATA_W-1:0]  dsr;
  logic [DATA_W-1:0]  rem;
  logic [CNT_W-1:0]   cnt;

  logic [DATA_W:0]    trial;
  logic [DATA_W-1:0]  rem_nxt, quo_nxt, rem_fix, quo_fix, mag1, mag2;

`ifdef DIV_SIGNED_EN
  logic neg_quo, neg_rem;
`else
  logic unused_signed;
  assign unused_signed = signed_i;
`endif

  // dvd doubles as the quotient: dividend bits shift out the top while quotient bits shift in.
  always_comb begin
    trial   = {1'b0, rem[DATA_W-2:0], dvd[DATA_W-1]} - {1'b0, dsr};
    rem_nxt = trial[DATA_W] ? {rem[DATA_W-2:0], dvd[DATA_W-1]} : trial[DATA_W-1:0];
    quo_nxt = {dvd[DATA_W-2:0], ~trial[DATA_W]};
`ifdef DIV_SIGNED_EN
    quo_fix = neg_quo ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem ? -rem_nxt : rem_nxt;
    mag1    = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    mag2    = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
`else
    quo_fix = quo_nxt;
    rem_fix = rem_nxt;
    mag1    = opdata1_i;
    mag2    = opdata2_i;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state <= DIV_ON;
              dvd   <= mag1;
              dsr   <= mag2;
              rem   <= '0;
              cnt   <= '0;
`ifdef DIV_SIGNED_EN
              neg_quo <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem <= signed_i && opdata1_i[DATA_W-1];
`endif
            end
          end
        end
        DIV_BYZERO: begin
          state    <= DIV_END;
          result_o <= '0;
        end
        DIV_ON: begin
          if (annul_i) begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            dvd <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
              state    <= DIV_END;
            end
          end
        end
        DIV_END: begin
          // Divide-by-zero arrives here with ready low; it is raised one edge later.
          if (!start_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o  <= 1'b1;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
// Honours DIV_SIGNED_EN the same way the design does.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int unsigned checks = 0;
  int unsigned errors = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .signed_i  (signed_i),
    .opdata1_i (opdata1),
    .opdata2_i (opdata2),
    .start_i   (start),
    .annul_i   (annul),
    .result_o  (result),
    .ready_o   (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Divide by magnitudes in 64-bit arithmetic, then restore signs (truncating division).
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ma, mb, q, r;
    bit na, nb;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    na = s && a[31];
    nb = s && b[31];
`else
    na = 1'b0;
    nb = 1'b0;
`endif
    ma = longint'({32'd0, a});
    mb = longint'({32'd0, b});
    if (na) ma = 64'sh1_0000_0000 - ma;
    if (nb) mb = 64'sh1_0000_0000 - mb;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Full handshake: accept, count edges to ready (operands scrambled meanwhile), hold, release.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, output logic [63:0] res);
    logic [63:0] exp;
    int unsigned lat;
    bit seen;
    exp = model(a, b, s);
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_i = s; start = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      opdata1 = $urandom; opdata2 = $urandom; signed_i = 1'($urandom);
      @(posedge clk); #1;
      if (ready) begin seen = 1'b1; lat = n; end
    end
    check({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd32);
    check({tag, "_res"}, result, exp);
    res = result;
    @(posedge clk); #1;
    check({tag, "_hold"}, {63'd0, ready}, 64'd1);
    check({tag, "_stable"}, result, exp);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop"}, {63'd0, ready}, 64'd0);
    check({tag, "_clr"}, result, 64'd0);
  endtask

  logic [63:0] res;
  logic [31:0] ra, rb;
  int unsigned hits;

  initial begin
    #12;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("divu100_7", 32'd100, 32'd7, 1'b0, res);
    check("divu100_7_const", res, 64'h00000002_0000000E);
    run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, res);
    run_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, res);
    run_div("divu_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, res);
    check("divu_ovf_const", res, 64'h80000000_00000000);
    run_div("divz_u", 32'd12345, 32'd0, 1'b0, res);
    run_div("divz_s", 32'hFFFFFFFF, 32'd0, 1'b1, res);
    run_div("divu_small_big", 32'd5, 32'hFFFFFFFF, 1'b0, res);
    run_div("divu_by1", 32'hFFFFFFFF, 32'd1, 1'b0, res);
    run_div("div_neg_div", 32'd100, 32'hFFFFFFF9, 1'b1, res);

    // Annul at iteration 10: no result may appear.
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_i = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    check("annul_noready", 64'(hits), 64'd0);
    check("annul_result", result, 64'd0);
    run_div("after_annul", 32'hFFFFFFFF, 32'h10, 1'b0, res);
    check("after_annul_const", res, 64'h0000000F_0FFFFFFF);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    opdata1 = 32'hDEADBEEF; opdata2 = 32'd17; signed_i = 1'b0; start = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, ready}, 64'd0);
    check("rst_mid_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("after_rst_mid", 32'hDEADBEEF, 32'd17, 1'b0, res);

    // Asynchronous reset while holding a result.
    @(negedge clk);
    opdata1 = 32'd999; opdata2 = 32'd10; signed_i = 1'b0; start = 1'b1;
    hits = 0;
    for (int n = 0; n < 40 && hits == 0; n++) begin
      @(posedge clk); #1;
      if (ready) hits = 1;
    end
    check("end_reached", 64'(hits), 64'd1);
    check("end_result", result, 64'h00000009_00000063);
    #2 rst = 1'b0;
    #1;
    check("rst_end_ready", {63'd0, ready}, 64'd0);
    check("rst_end_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("after_rst_end", 32'h12345678, 32'h00000123, 1'b0, res);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = rb >> $urandom_range(1, 31);
        default: ;
      endcase
      run_div("rand", ra, rb, 1'($urandom), res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage, executing MIPS DIV/DIVU. It sits directly upstream of the HI/LO register. The remainder goes to HI and the quotient goes to LO. It uses a radix-2 restoring algorithm, one quotient bit per clock. The pipeline controller stalls on `start_i && !ready_o`.

## Interface
- `DATA_W`, default 32: operand width. The iteration count equals `DATA_W`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `signed_i` input 1: 1 = DIV (signed), 0 = DIVU. Sampled on the edge that accepts `start_i`.
- `opdata1_i` input DATA_W: dividend. Sampled on the accept edge.
- `opdata2_i` input DATA_W: divisor. Sampled on the accept edge.
- `start_i` input 1: request; held high by EX until the result is consumed.
- `annul_i` input 1: cancel, asserted on a pipeline flush or exception.
- `result_o` output 2*DATA_W: `{remainder, quotient}`, mapped as hi = [63:32] and lo = [31:0].
- `ready_o` output 1: `result_o` is valid.

## Operation
- FSM states: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END. The reset state is DIV_FREE.
- DIV_FREE:
  - `start_i && !annul_i && opdata2_i == 0` → DIV_BYZERO.
  - `start_i && !annul_i` with a nonzero divisor → DIV_ON. On this edge:
    - latch the operand magnitudes (two's-complement negate if `signed_i` and the MSB is set);
    - latch the sign flags;
    - set the partial remainder to 0;
    - set the iteration counter to 0.
  - Otherwise stay.
- DIV_BYZERO → DIV_END. The result is hi = 0 and lo = 0 (defined value; the architecture leaves it unpredictable).
- DIV_ON, each edge:
  - trial = `{rem[DATA_W-2:0], dividend_msb} − divisor` (DATA_W+1-bit subtract);
  - if trial ≥ 0, rem = trial[DATA_W-1:0] and shift 1 into the quotient; else shift only and shift 0 into the quotient;
  - counter++.
- DIV_ON completion: on the edge where counter == DATA_W−1, apply the sign fix-up, register `result_o`, and go to DIV_END.
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - Both fix-ups apply only when signed.
- DIV_ON with `annul_i` = 1: go to DIV_FREE next edge; `result_o` = 0; `ready_o` stays 0. `annul_i` has priority over the step and over completion.
- DIV_END:
  - `ready_o` = 1 and `result_o` is held stable.
  - When `start_i` = 0, go to DIV_FREE; `result_o` clears to 0.
  - `annul_i` is ignored in this state.
- Overflow case: signed −2^31 / −1 gives lo = 0x80000000 and hi = 0 (wraps naturally; no trap).
- Reset (asynchronous assert, mid-operation included): state = DIV_FREE, `ready_o` = 0, `result_o` = 0, counter = 0, and all internal registers = 0.

## Timing
- Accept edge k. For a nonzero divisor, `ready_o` rises after edge k+DATA_W (32 cycles of stall).
- For a divisor of 0, `ready_o` rises after edge k+2.
- `ready_o` and `result_o` are registered outputs with no combinational path from the inputs.
- `ready_o` stays high while `start_i` is held. It falls one edge after `start_i` drops.
- The earliest back-to-back re-accept is one cycle after returning to DIV_FREE.
- Operand changes during DIV_ON/DIV_END have no effect.
- `start_i` in DIV_BYZERO/DIV_ON/DIV_END does not restart a divide.

## Configuration
- `DIV_SIGNED_EN` defined: full DIV/DIVU support as above.
- Not defined:
  - `signed_i` is ignored and all divides are unsigned;
  - the magnitude-negation and sign-fix-up logic is removed;
  - DIV instructions then produce DIVU results;
  - timing is identical.

## Test plan
- DIVU 100 / 7, `start_i` held → `ready_o` high after exactly 32 edges; `result_o` = {0x00000002, 0x0000000E}.
- DIV −7 / 2 (0xFFFFFFF9 / 2, signed) → hi = 0xFFFFFFFF, lo = 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF, signed → hi = 0, lo = 0x80000000. DIVU with the same operands → hi = 0x80000000, lo = 0.
- Divide by zero (any dividend) → `ready_o` after 2 edges; `result_o` = 0.
- `annul_i` pulsed at iteration 10 → FSM returns to DIV_FREE; `ready_o` never rises. A following 0xFFFFFFFF / 0x10 (DIVU) gives lo = 0x0FFFFFFF, hi = 0xF.
- `rst` asserted asynchronously mid-divide and in DIV_END → `ready_o` and `result_o` go to 0 immediately. After release, a new divide completes correctly in 32 cycles.
